// File: rtl/vc_arbiter.sv
// Two-virtual-channel arbiter: one circular FIFO per VC, popped one word per edge
// with strict VC0 priority, downstream pause, and a sticky overflow flag.
module vc_arbiter #(
  parameter int DATA_WIDTH = 6,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  push0,
  input  logic [DATA_WIDTH-1:0] data_in0,
  input  logic                  push1,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic                  pause,
  output logic [DATA_WIDTH-1:0] data_out0,
  output logic                  valid_out0,
  output logic [DATA_WIDTH-1:0] data_out1,
  output logic                  valid_out1,
  output logic                  selector,
  output logic                  empty0,
  output logic                  empty1,
  output logic                  full0,
  output logic                  full1,
  output logic                  error
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ZERO_COUNT = {(ADDR_WIDTH + 1){1'b0}};

  logic [ADDR_WIDTH-1:0] wr_ptr_r [2];
  logic [ADDR_WIDTH-1:0] rd_ptr_r [2];
  logic [ADDR_WIDTH:0]   count_r  [2];
  logic [DATA_WIDTH-1:0] mem_r    [2][DEPTH];

  logic [DATA_WIDTH-1:0] data_out0_r;
  logic [DATA_WIDTH-1:0] data_out1_r;
  logic                  valid_out0_r;
  logic                  valid_out1_r;
  logic                  selector_r;
  logic                  error_r;

  logic [1:0]            push_s;
  logic [1:0]            empty_s;
  logic [1:0]            full_s;
  logic [1:0]            pop_s;
  logic [1:0]            wr_s;
  logic                  drop_s;
  logic [DATA_WIDTH-1:0] data_in_s [2];

  // Status decode from registered counts and the per-edge pop/push decision
  always_comb begin
    push_s       = {push1, push0};
    data_in_s[0] = data_in0;
    data_in_s[1] = data_in1;
    empty_s[0]   = (count_r[0] == ZERO_COUNT);
    empty_s[1]   = (count_r[1] == ZERO_COUNT);
    full_s[0]    = (count_r[0] == FULL_COUNT);
    full_s[1]    = (count_r[1] == FULL_COUNT);
    pop_s        = 2'b00;
    if (pause) begin
      pop_s = 2'b00;
    end else if (!empty_s[0]) begin
      pop_s = 2'b01;
    end else if (!empty_s[1]) begin
      pop_s = 2'b10;
    end else begin
      pop_s = 2'b00;
    end
    // A full FIFO still accepts a push when the same edge frees its head slot
    wr_s   = push_s & (~full_s | pop_s);
    drop_s = |(push_s & full_s & ~pop_s);
  end

  // FIFO pointers and occupancy counts
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int v = 0; v < 2; v++) begin
        wr_ptr_r[v] <= {ADDR_WIDTH{1'b0}};
        rd_ptr_r[v] <= {ADDR_WIDTH{1'b0}};
        count_r[v]  <= ZERO_COUNT;
      end
    end else begin
      for (int v = 0; v < 2; v++) begin
        if (wr_s[v]) begin
          wr_ptr_r[v] <= wr_ptr_r[v] + ADDR_WIDTH'(1);
        end
        if (pop_s[v]) begin
          rd_ptr_r[v] <= rd_ptr_r[v] + ADDR_WIDTH'(1);
        end
        case ({wr_s[v], pop_s[v]})
          2'b10:   count_r[v] <= count_r[v] + (ADDR_WIDTH + 1)'(1);
          2'b01:   count_r[v] <= count_r[v] - (ADDR_WIDTH + 1)'(1);
          default: count_r[v] <= count_r[v];
        endcase
      end
    end
  end

  // Storage array; contents need no reset since counts gate every read
  always_ff @(posedge clk) begin
    for (int v = 0; v < 2; v++) begin
      if (wr_s[v]) begin
        mem_r[v][wr_ptr_r[v]] <= data_in_s[v];
      end
    end
  end

  // Registered downstream outputs and sticky overflow flag
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_out0_r  <= {DATA_WIDTH{1'b0}};
      data_out1_r  <= {DATA_WIDTH{1'b0}};
      valid_out0_r <= 1'b0;
      valid_out1_r <= 1'b0;
      selector_r   <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      if (pop_s[0]) begin
        data_out0_r  <= mem_r[0][rd_ptr_r[0]];
        valid_out0_r <= 1'b1;
        valid_out1_r <= 1'b0;
        selector_r   <= 1'b0;
      end else if (pop_s[1]) begin
        data_out1_r  <= mem_r[1][rd_ptr_r[1]];
        valid_out0_r <= 1'b0;
        valid_out1_r <= 1'b1;
        selector_r   <= 1'b1;
      end else begin
        valid_out0_r <= 1'b0;
        valid_out1_r <= 1'b0;
      end
      if (drop_s) begin
        error_r <= 1'b1;
      end
    end
  end

  assign data_out0  = data_out0_r;
  assign data_out1  = data_out1_r;
  assign valid_out0 = valid_out0_r;
  assign valid_out1 = valid_out1_r;
  assign selector   = selector_r;
  assign error      = error_r;
  assign empty0     = empty_s[0];
  assign empty1     = empty_s[1];
  assign full0      = full_s[0];
  assign full1      = full_s[1];

endmodule

// File: tb/tb_vc_arbiter.sv
// Bench for vc_arbiter: directed scenarios then random traffic, every edge checked
// against a queue-based model of the two channels.
module tb_vc_arbiter;
  localparam int DW    = 6;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset_L;
  logic          push0, push1, pause;
  logic [DW-1:0] data_in0, data_in1;
  logic [DW-1:0] data_out0, data_out1;
  logic          valid_out0, valid_out1, selector;
  logic          empty0, empty1, full0, full1, error;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW-1:0] m_d0, m_d1;
  logic          m_v0, m_v1, m_sel, m_err;

  vc_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(2)) dut (
    .clk(clk), .reset_L(reset_L),
    .push0(push0), .data_in0(data_in0),
    .push1(push1), .data_in1(data_in1),
    .pause(pause),
    .data_out0(data_out0), .valid_out0(valid_out0),
    .data_out1(data_out1), .valid_out1(valid_out1),
    .selector(selector),
    .empty0(empty0), .empty1(empty1), .full0(full0), .full1(full1),
    .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q0.delete();
    q1.delete();
    m_d0 = '0; m_d1 = '0; m_v0 = 1'b0; m_v1 = 1'b0; m_sel = 1'b0; m_err = 1'b0;
  endtask

  // One clock edge of the reference: pop from pre-edge contents, then push into free room
  task automatic model_edge();
    bit e0, e1;
    e0 = (q0.size() == 0);
    e1 = (q1.size() == 0);
    if (!pause && !e0) begin
      m_d0 = q0.pop_front(); m_v0 = 1'b1; m_v1 = 1'b0; m_sel = 1'b0;
    end else if (!pause && !e1) begin
      m_d1 = q1.pop_front(); m_v0 = 1'b0; m_v1 = 1'b1; m_sel = 1'b1;
    end else begin
      m_v0 = 1'b0; m_v1 = 1'b0;
    end
    if (push0) begin
      if (q0.size() < DEPTH) q0.push_back(data_in0);
      else m_err = 1'b1;
    end
    if (push1) begin
      if (q1.size() < DEPTH) q1.push_back(data_in1);
      else m_err = 1'b1;
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".data_out0"},  data_out0,  m_d0);
    chk({ctx, ".data_out1"},  data_out1,  m_d1);
    chk({ctx, ".valid_out0"}, valid_out0, m_v0);
    chk({ctx, ".valid_out1"}, valid_out1, m_v1);
    chk({ctx, ".selector"},   selector,   m_sel);
    chk({ctx, ".error"},      error,      m_err);
    chk({ctx, ".empty0"},     empty0,     q0.size() == 0);
    chk({ctx, ".empty1"},     empty1,     q1.size() == 0);
    chk({ctx, ".full0"},      full0,      q0.size() == DEPTH);
    chk({ctx, ".full1"},      full1,      q1.size() == DEPTH);
  endtask

  task automatic step(input string ctx, input logic p0, input logic [DW-1:0] d0,
                      input logic p1, input logic [DW-1:0] d1, input logic ps);
    push0 = p0; data_in0 = d0; push1 = p1; data_in1 = d1; pause = ps;
    @(posedge clk);
    if (reset_L) model_edge();
    #1;
    check_all(ctx);
  endtask

  task automatic mid_cycle_reset(input string ctx);
    #2;
    reset_L = 1'b0;
    model_clear();
    #1;
    check_all(ctx);
    step({ctx, "_held"}, 1'b1, 6'h2a, 1'b1, 6'h2b, 1'b0);
    reset_L = 1'b1;
  endtask

  initial begin
    reset_L = 1'b0;
    push0 = 1'b0; push1 = 1'b0; pause = 1'b0;
    data_in0 = '0; data_in1 = '0;
    model_clear();
    #1;
    check_all("reset");
    step("reset_push", 1'b1, 6'h3f, 1'b1, 6'h3e, 1'b0);
    reset_L = 1'b1;

    // Single word latency through VC0
    step("lat_push", 1'b1, 6'h15, 1'b0, 6'h00, 1'b0);
    step("lat_out", 1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
    chk("lat_data_direct", data_out0, 32'h15);
    step("lat_idle", 1'b0, 6'h00, 1'b0, 6'h00, 1'b0);

    // Fill both channels under pause, then drain: VC0 first, VC1 after
    for (int i = 1; i <= 4; i++)
      step("fill", 1'b1, DW'(i), 1'b1, DW'(16 + i), 1'b1);
    for (int i = 0; i < 9; i++)
      step("drain", 1'b0, 6'h00, 1'b0, 6'h00, 1'b0);

    // Overflow on VC1 while paused
    for (int i = 0; i < 5; i++)
      step("ovf_fill", 1'b0, 6'h00, 1'b1, DW'(32 + i), 1'b1);
    chk("ovf_error_direct", error, 32'h1);
    for (int i = 0; i < 6; i++)
      step("ovf_drain", 1'b0, 6'h00, 1'b0, 6'h00, 1'b0);

    // Full VC0 accepts a push on a popping edge without raising error
    reset_L = 1'b0;
    model_clear();
    #1;
    check_all("rst2");
    reset_L = 1'b1;
    for (int i = 0; i < 4; i++)
      step("full_fill", 1'b1, DW'(40 + i), 1'b0, 6'h00, 1'b1);
    step("full_pushpop", 1'b1, 6'h30, 1'b0, 6'h00, 1'b0);
    chk("full_pushpop_direct", full0, 32'h1);
    for (int i = 0; i < 5; i++)
      step("full_drain", 1'b0, 6'h00, 1'b0, 6'h00, 1'b0);

    // Asynchronous reset with both channels holding data
    step("rst_fill", 1'b1, 6'h0a, 1'b1, 6'h1a, 1'b1);
    step("rst_fill", 1'b1, 6'h0b, 1'b1, 6'h1b, 1'b1);
    mid_cycle_reset("async_rst");
    for (int i = 0; i < 3; i++)
      step("post_rst", 1'b0, 6'h00, 1'b0, 6'h00, 1'b0);

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        mid_cycle_reset("rnd_rst");
      end else begin
        step("rnd",
             1'($urandom_range(0, 9) < 6), DW'($urandom),
             1'($urandom_range(0, 9) < 6), DW'($urandom),
             1'($urandom_range(0, 3) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vc_arbiter.md
VC_ARBITER -- requirements
Module: vc_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 6, SHALL set the word width of every data port.
REQ-002 Parameter DEPTH, default 4, SHALL set the entries per virtual-channel FIFO (power of two).
REQ-003 Parameter ADDR_WIDTH, default 2, SHALL be log2(DEPTH).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset_L  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 push0  input  1  SHALL be the VC0 write request.
REQ-007 data_in0  input  DATA_WIDTH  SHALL be the VC0 write word.
REQ-008 push1  input  1  SHALL be the VC1 write request.
REQ-009 data_in1  input  DATA_WIDTH  SHALL be the VC1 write word.
REQ-010 pause  input  1  SHALL be downstream backpressure; 1 inhibits any pop.
REQ-011 data_out0  output  DATA_WIDTH  SHALL be the last word popped from VC0 (registered).
REQ-012 valid_out0  output  1  SHALL mark a fresh VC0 word this cycle (registered).
REQ-013 data_out1  output  DATA_WIDTH  SHALL be the last word popped from VC1 (registered).
REQ-014 valid_out1  output  1  SHALL mark a fresh VC1 word this cycle (registered).
REQ-015 selector  output  1  SHALL be the downstream mux select: 0 = VC0, 1 = VC1 (registered).
REQ-016 empty0, empty1  output  1 each  SHALL flag count==0 per FIFO.
REQ-017 full0, full1  output  1 each  SHALL flag count==DEPTH per FIFO.
REQ-018 error  output  1  SHALL be a sticky overflow flag.

Function
REQ-019 Each VC SHALL be a circular FIFO: write pointer, read pointer (ADDR_WIDTH bits, wrap mod DEPTH), count (ADDR_WIDTH+1 bits).
REQ-020 empty*/full* SHALL be decoded combinationally from the registered counts only.
REQ-021 A push SHALL store the word at the write pointer and advance it when the FIFO is not full pre-edge, or is full with a same-edge pop of that FIFO.
REQ-022 A push to a full FIFO with no same-edge pop SHALL be dropped, leave the FIFO unchanged and set error, which holds 1 until reset.
REQ-023 Pop decision per edge, using pre-edge state: pause=1 -> no pop; else !empty0 -> pop VC0; else !empty1 -> pop VC1; else no pop (strict VC0 priority).
REQ-024 An empty FIFO SHALL never be popped; a same-edge push to an empty FIFO is stored and poppable at the next edge at the earliest.
REQ-025 Pop of VCn SHALL register data_outn = head word, valid_outn = 1, the other valid_out = 0, and selector = n, all on the same edge.
REQ-026 Edge without pop SHALL drive valid_out0 = valid_out1 = 0 and hold data_out0, data_out1 and selector.
REQ-027 At most one of valid_out0/valid_out1 SHALL be 1 in any cycle.
REQ-028 Latency: a word pushed at edge N into an empty VC0 with pause=0 SHALL appear at edge N+1.
REQ-029 Simultaneous push and pop on one FIFO SHALL leave its count unchanged.
REQ-030 Asserting pause SHALL take effect at the same edge (no pop at any edge sampling pause=1); FIFO contents are preserved.

Reset
REQ-031 reset_L=0 SHALL immediately, without waiting for clk, clear all pointers and counts, data_out0, data_out1, valid_out0, valid_out1, selector and error to 0.
REQ-032 During reset, empty0 = empty1 = 1 and full0 = full1 = 0; pushes are ignored.
REQ-033 Reset asserted mid-traffic SHALL discard all stored words; first edge after release behaves as from empty.

Verification
REQ-034 Push 0x15 into VC0 at edge 1, pause=0 -> edge 2: data_out0=0x15, valid_out0=1, selector=0; edge 3: valid_out0=0.
REQ-035 Fill VC0 and VC1 with 4 words each (0x01-0x04, 0x11-0x14), pause=0 -> 0x01-0x04 on VC0, then 0x11-0x14 on VC1 with selector=1, no gaps.
REQ-036 pause=1, push 5 words into VC1 -> full1=1 after 4, 5th dropped, error=1 and stays 1; release pause -> exactly 4 words out.
REQ-037 Full VC0 with push0 and pause=0 on the same edge -> word accepted, count stays 4, error stays 0.
REQ-038 Assert reset_L=0 between clock edges with both FIFOs non-empty -> outputs 0 immediately, empty0=empty1=1; after release no stale word pops.
